// File: rtl/misaligned_access_sequencer_pkg.sv
// Shared encodings and defaults for the misaligned access sequencer.
// Access sizes, data-memory window defaults and FSM state codes.
package misaligned_access_sequencer_pkg;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] SIZE_DOUBLE = 2'b11;

    localparam logic [31:0] DATA_BEGIN_DEF = 32'h0001_0000;
    localparam logic [31:0] DATA_END_DEF   = 32'h0001_1FFF;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LO   = 3'd1;
    localparam logic [2:0] ST_HI   = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    function automatic logic [3:0] size_nbytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/misaligned_access_sequencer_load_data_aligner.sv
// Combinational load-data aligner: shifts the two-word load buffer down to
// the access offset, truncates to the access size and sign/zero-extends.
module misaligned_access_sequencer_load_data_aligner
    import misaligned_access_sequencer_pkg::*;
(
    input  logic [127:0] i_data,
    input  logic [2:0]   i_off,
    input  logic [1:0]   i_size,
    input  logic         i_signed,
    output logic [63:0]  o_rdata
);

    logic [63:0] w_low;

    assign w_low = 64'(i_data >> {i_off, 3'b000});

    always_comb begin
        o_rdata = w_low;
        case (i_size)
            SIZE_BYTE:   o_rdata = {{56{i_signed & w_low[7]}},  w_low[7:0]};
            SIZE_HALF:   o_rdata = {{48{i_signed & w_low[15]}}, w_low[15:0]};
            SIZE_WORD:   o_rdata = {{32{i_signed & w_low[31]}}, w_low[31:0]};
            default:     o_rdata = w_low;
        endcase
    end

endmodule

// File: rtl/misaligned_access_sequencer.sv
// Load/store sequencer in front of the 64-bit data RAM; splits accesses that
// cross an 8-byte boundary into two aligned RAM cycles and merges the result.
module misaligned_access_sequencer
    import misaligned_access_sequencer_pkg::*;
#(
    parameter logic [31:0] DATA_BEGIN = DATA_BEGIN_DEF,
    parameter logic [31:0] DATA_END   = DATA_END_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_address,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic [28:0] mem_address,
    output logic [7:0]  mem_byte_mask,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    logic [2:0]  r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [63:0] r_wdata;
    logic        r_read;
    logic        r_fault;
    logic [63:0] r_buf_lo;
    logic [63:0] r_buf_hi;

    logic [3:0]   w_req_nbytes;
    logic [32:0]  w_req_last;
    logic         w_req_fault;
    logic [2:0]   w_off;
    logic [3:0]   w_nbytes;
    logic         w_cross;
    logic [15:0]  w_mask16;
    logic [63:0]  w_wtrunc;
    logic [127:0] w_wdata128;
    logic [28:0]  w_word_lo;
    logic [28:0]  w_word_hi;
    logic [63:0]  w_aligned;

    // Range check in 33 bits so an address near 2^32 cannot wrap past DATA_END.
    assign w_req_nbytes = size_nbytes(req_size);
    assign w_req_last   = {1'b0, req_address} + 33'(w_req_nbytes) - 33'd1;
    assign w_req_fault  = (req_address < DATA_BEGIN) ||
                          (w_req_last > {1'b0, DATA_END}) ||
                          (req_read == req_write);

    assign w_off      = r_addr[2:0];
    assign w_nbytes   = size_nbytes(r_size);
    assign w_cross    = ({1'b0, w_off} + w_nbytes) > 4'd8;
    assign w_mask16   = ((16'd1 << w_nbytes) - 16'd1) << w_off;
    assign w_word_lo  = r_addr[31:3];
    assign w_word_hi  = w_word_lo + 29'd1;
    assign w_wdata128 = {64'd0, w_wtrunc} << {w_off, 3'b000};

    always_comb begin
        w_wtrunc = r_wdata;
        case (r_size)
            SIZE_BYTE: w_wtrunc = {56'd0, r_wdata[7:0]};
            SIZE_HALF: w_wtrunc = {48'd0, r_wdata[15:0]};
            SIZE_WORD: w_wtrunc = {32'd0, r_wdata[31:0]};
            default:   w_wtrunc = r_wdata;
        endcase
    end

    misaligned_access_sequencer_load_data_aligner u_aligner (
        .i_data   ({r_buf_hi, r_buf_lo}),
        .i_off    (w_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_rdata  (w_aligned)
    );

    always_comb begin
        mem_address   = '0;
        mem_byte_mask = '0;
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;
        mem_wdata     = '0;
        case (r_state)
            ST_LO: begin
                mem_address   = w_word_lo;
                mem_byte_mask = w_mask16[7:0];
                mem_read_en   = r_read;
                mem_write_en  = !r_read;
                mem_wdata     = w_wdata128[63:0];
            end
            ST_HI: begin
                mem_address   = w_word_hi;
                mem_byte_mask = w_mask16[15:8];
                mem_read_en   = r_read;
                mem_write_en  = !r_read;
                mem_wdata     = w_wdata128[127:64];
            end
            default: ;
        endcase
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_fault = resp_valid && r_fault;
    assign resp_rdata = (resp_valid && r_read && !r_fault) ? w_aligned : 64'd0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_wdata  <= '0;
            r_read   <= 1'b0;
            r_fault  <= 1'b0;
            r_buf_lo <= '0;
            r_buf_hi <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr   <= req_address;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_wdata  <= req_wdata;
                        r_read   <= req_read;
                        r_fault  <= w_req_fault;
                        r_state  <= w_req_fault ? ST_RESP : ST_LO;
                    end
                end
                ST_LO: begin
                    if (w_cross)     r_state <= ST_HI;
                    else if (r_read) r_state <= ST_DONE;
                    else             r_state <= ST_RESP;
                end
                ST_HI: begin
                    // The LO read returns while HI is on the bus.
                    if (r_read) r_buf_lo <= mem_rdata;
                    r_state <= r_read ? ST_DONE : ST_RESP;
                end
                ST_DONE: begin
                    if (w_cross) r_buf_hi <= mem_rdata;
                    else         r_buf_lo <= mem_rdata;
                    r_state <= ST_RESP;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_misaligned_access_sequencer.sv
// Directed bench for misaligned_access_sequencer with a 1-cycle-latency RAM model.
module tb_misaligned_access_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_address;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [28:0] mem_address;
    logic [7:0]  mem_byte_mask;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'd0;

    logic [63:0] ram [logic [28:0]];
    logic [63:0] r_wr_word;

    int n_cmp = 0;
    int n_err = 0;

    logic [28:0] rec_a  [4];
    logic [7:0]  rec_m  [4];
    logic [63:0] rec_wd [4];

    misaligned_access_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_address   (req_address),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_fault    (resp_fault),
        .mem_address   (mem_address),
        .mem_byte_mask (mem_byte_mask),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_read_en)
            mem_rdata <= ram.exists(mem_address) ? ram[mem_address] : 64'd0;
        if (mem_write_en) begin
            r_wr_word = ram.exists(mem_address) ? ram[mem_address] : 64'd0;
            for (int i = 0; i < 8; i++)
                if (mem_byte_mask[i]) r_wr_word[8*i +: 8] = mem_wdata[8*i +: 8];
            ram[mem_address] = r_wr_word;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                       input logic [63:0] wd, input int exp_lat, input logic [63:0] exp_data,
                       input logic exp_fault, input int exp_n,
                       input logic [28:0] a0, input logic [7:0] m0,
                       input logic [28:0] a1, input logic [7:0] m1);
        int n;
        int lat;
        logic [63:0] data;
        logic fault;
        n = 0; lat = 0; data = 'x; fault = 1'bx;
        @(negedge clk);
        chk({tag, "/ready_idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_read = rd; req_write = wr; req_size = sz;
        req_signed = sg; req_address = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, "/ready_busy"}, 64'(req_ready), 64'd0);
            if (mem_read_en || mem_write_en) begin
                if (n < 4) begin
                    rec_a[n] = mem_address; rec_m[n] = mem_byte_mask; rec_wd[n] = mem_wdata;
                end
                n++;
            end
            if (resp_valid) begin
                lat = k; data = resp_rdata; fault = resp_fault;
                break;
            end
        end
        chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "/rdata"}, data, exp_data);
        chk({tag, "/fault"}, 64'(fault), 64'(exp_fault));
        chk({tag, "/nstrobes"}, 64'(n), 64'(exp_n));
        if (exp_n >= 1 && n >= 1) begin
            chk({tag, "/addr0"}, 64'(rec_a[0]), 64'(a0));
            chk({tag, "/mask0"}, 64'(rec_m[0]), 64'(m0));
        end
        if (exp_n >= 2 && n >= 2) begin
            chk({tag, "/addr1"}, 64'(rec_a[1]), 64'(a1));
            chk({tag, "/mask1"}, 64'(rec_m[1]), 64'(m1));
        end
        @(negedge clk);
        chk({tag, "/resp_one_cycle"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=no_finish expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        ram[29'h2000] = 64'h8877665544332211;
        ram[29'h2001] = 64'hFFEEDDCCBBAA9988;
        reset_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_size = 2'b00; req_signed = 1'b0; req_address = '0; req_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset/ready", 64'(req_ready), 64'd1);
        chk("reset/resp_valid", 64'(resp_valid), 64'd0);
        chk("reset/resp_rdata", resp_rdata, 64'd0);
        chk("reset/strobes", 64'({mem_read_en, mem_write_en}), 64'd0);
        chk("reset/mask", 64'(mem_byte_mask), 64'd0);
        reset_n = 1'b1;

        run("ld_w_signed", 1, 0, 2'b10, 1, 32'h0001_0004, 0, 3, 64'hFFFFFFFF88776655, 0, 1,
            29'h2000, 8'hF0, 0, 0);
        run("ld_d_cross", 1, 0, 2'b11, 0, 32'h0001_0006, 0, 4, 64'hDDCCBBAA99888877, 0, 2,
            29'h2000, 8'hC0, 29'h2001, 8'h3F);
        run("st_h_cross", 0, 1, 2'b01, 0, 32'h0001_0007, 64'h1111_2222_3333_ABCD, 3, 64'd0, 0, 2,
            29'h2000, 8'h80, 29'h2001, 8'h01);
        chk("st_h_cross/lane_lo", 64'(rec_wd[0][63:56]), 64'hCD);
        chk("st_h_cross/lane_hi", 64'(rec_wd[1][7:0]), 64'hAB);
        run("ld_h_cross", 1, 0, 2'b01, 0, 32'h0001_0007, 0, 4, 64'h000000000000ABCD, 0, 2,
            29'h2000, 8'h80, 29'h2001, 8'h01);
        run("ld_b_u_44", 1, 0, 2'b00, 0, 32'h0001_0003, 0, 3, 64'h44, 0, 1, 29'h2000, 8'h08, 0, 0);
        run("ld_b_s_ff", 1, 0, 2'b00, 1, 32'h0001_000F, 0, 3, 64'hFFFFFFFFFFFFFFFF, 0, 1,
            29'h2001, 8'h80, 0, 0);
        run("ld_b_u_ff", 1, 0, 2'b00, 0, 32'h0001_000F, 0, 3, 64'hFF, 0, 1, 29'h2001, 8'h80, 0, 0);
        run("st_b_align", 0, 1, 2'b00, 0, 32'h0001_0010, 64'hFFFF_FFFF_FFFF_FF5A, 2, 64'd0, 0, 1,
            29'h2002, 8'h01, 0, 0);
        run("ld_b_5a", 1, 0, 2'b00, 1, 32'h0001_0010, 0, 3, 64'h5A, 0, 1, 29'h2002, 8'h01, 0, 0);
        run("flt_end", 1, 0, 2'b10, 0, 32'h0001_1FFE, 0, 1, 64'd0, 1, 0, 0, 0, 0, 0);
        run("flt_rw", 1, 1, 2'b11, 0, 32'h0001_0000, 0, 1, 64'd0, 1, 0, 0, 0, 0, 0);
        run("flt_low", 1, 0, 2'b00, 0, 32'h0000_FFFF, 0, 1, 64'd0, 1, 0, 0, 0, 0, 0);
        run("flt_none", 0, 0, 2'b00, 0, 32'h0001_0000, 0, 1, 64'd0, 1, 0, 0, 0, 0, 0);
        run("ld_last_ok", 1, 0, 2'b10, 0, 32'h0001_1FFC, 0, 3, 64'd0, 0, 1, 29'h23FF, 8'hF0, 0, 0);

        // Abort a crossing store while it is in its HI cycle.
        @(negedge clk);
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_size = 2'b01;
        req_signed = 1'b0; req_address = 32'h0001_0007; req_wdata = 64'h1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid/lo_write", 64'(mem_write_en), 64'd1);
        @(negedge clk);
        chk("rst_mid/hi_addr", 64'(mem_address), 64'h2001);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid/strobes", 64'({mem_read_en, mem_write_en}), 64'd0);
        chk("rst_mid/resp_valid", 64'(resp_valid), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid/ready", 64'(req_ready), 64'd1);
        chk("rst_mid/no_resp", 64'(resp_valid), 64'd0);
        run("post_rst_ld", 1, 0, 2'b00, 0, 32'h0001_0003, 0, 3, 64'h44, 0, 1, 29'h2000, 8'h08, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
